freq_ring_sequencer: RTL and testbench
======================================

# freq_ring_sequencer

Sequencer that steps the frequency-selector ring buffers on the device clock. It issues read-advance pulses to the first (14-bit tone) and second (4-bit) rings at a programmable dwell period, and tracks the current tone index and sweep boundaries. It defers stepping while the AXI side holds the rings for index writes or random reads. It drives the `rd_en_first`/`rd_en_second` inputs of the frequency-selector core.

## Interface

Parameters:
- `DWELL_W`, 16: width of the dwell period input.
- `IDX_W`, 7: width of the tone index, matching the 128-deep rings.

Ports:
- `dev_clk`  in  1  device clock; the block's only clock.
- `dev_rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  level; the sequencer runs while high.
- `dwell`  in  DWELL_W  step period minus one, in `dev_clk` cycles.
- `num_tones`  in  IDX_W  number of tones in a sweep; 0 means stop.
- `second_div`  in  4  second ring advances once per `second_div`+1 first-ring steps.
- `ring_hold`  in  1  rings busy (AXI write or random read); already synchronous to `dev_clk`.
- `clr_stats`  in  1  one-cycle pulse; clears `stall_cnt`.
- `rd_en_first`  out  1  one-cycle advance pulse for the first ring.
- `rd_en_second`  out  1  one-cycle advance pulse for the second ring.
- `tone_idx`  out  IDX_W  index of the tone currently presented.
- `sweep_start`  out  1  one-cycle pulse when tone 0 becomes current.
- `running`  out  1  high in any state other than IDLE.
- `stall_cnt`  out  8  number of steps deferred by `ring_hold`; saturates at 8'hFF.

## Operation

- States are IDLE, DWELL and HOLD, with a dwell counter `cnt`, a sub-step counter `sub` (4 bits) and a latched sweep length `n_lat`.
- All outputs are registered. Reset (async) forces:
  - state to IDLE;
  - `cnt`, `sub`, `n_lat`, `tone_idx`, `stall_cnt` to 0;
  - all pulse outputs to 0.
- **IDLE:**
  - On `enable`=1 and `num_tones`≠0: go to DWELL, latch `n_lat`=`num_tones`, load `cnt`=`dwell`, set `tone_idx`=0 and `sub`=0, and pulse `sweep_start`.
  - Otherwise remain in IDLE.
- **DWELL:**
  - While `cnt`≠0, decrement `cnt`.
  - At `cnt`=0 with `ring_hold`=0, perform a step.
  - At `cnt`=0 with `ring_hold`=1, go to HOLD and increment `stall_cnt` (saturating).
- **HOLD:**
  - `cnt` stays at 0.
  - The first edge with `ring_hold`=0 performs a step and returns to DWELL.
- **Step** (a single edge), with these effects:
  - `rd_en_first`=1 for one cycle and `cnt` reloads `dwell`.
  - `tone_idx` increments. If it was `n_lat`−1, it wraps to 0, `sweep_start` pulses coincident with `rd_en_first`, and `n_lat` re-latches `num_tones`.
  - If `sub`=`second_div`: `rd_en_second`=1 coincident with `rd_en_first` and `sub`=0. Otherwise `sub` increments.
- **Wrap with `num_tones`=0:** the wrap step still issues its pulses; the state then goes to IDLE instead of DWELL.
- **Deassertion of `enable`:** sampled in DWELL or HOLD, it moves to IDLE on that edge. No further pulses are issued, and `tone_idx` holds its value until the next start.
- **Priority:** `enable` deassertion beats a step on the same edge, so no pulse is issued.
- **Inputs sampled at step time:** `dwell` and `second_div` take effect from their next reload/compare. `num_tones` is used only at start and at wrap.
- **`clr_stats`:** zeroes `stall_cnt`. If an increment coincides, the result is 0.

## Timing

- The IDLE→DWELL transition at edge E is the start edge; `sweep_start` is high during cycle E.
- The first `rd_en_first` is at edge E+`dwell`+1. Later pulses follow every `dwell`+1 edges while `ring_hold` stays low.
- With `dwell`=0, `rd_en_first` pulses on every cycle.
- If HOLD lasts H cycles, the step is delayed by exactly H cycles; subsequent pulses are spaced from the delayed step.
- `rd_en_first`, `rd_en_second` and `sweep_start` are never high for two consecutive cycles unless `dwell`=0.
- `tone_idx` updates on the same edge that raises `rd_en_first`.
- Reset mid-operation: all outputs are 0 immediately (asynchronously). After release the block is in IDLE and needs a new `enable`-high sample to start.

## Test plan

- `dwell`=3, `num_tones`=4, `second_div`=0, `enable` held high from the start edge E → `rd_en_first` at E+4, E+8, E+12, E+16. `tone_idx` steps 1,2,3,0. `sweep_start` pulses at E and E+16. `rd_en_second` is coincident with every `rd_en_first`.
- `second_div`=2, `dwell`=0, `num_tones`=8 → `rd_en_second` on steps 3, 6 and 9 only.
- `ring_hold` high for 5 cycles covering the cycle where `cnt` reaches 0 (`dwell`=3) → that step is delayed by 5 cycles and `stall_cnt`=1. A second hold event gives `stall_cnt`=2. `clr_stats` then gives 0.
- `num_tones` changed from 4 to 2 mid-sweep → the old sweep completes 4 steps, then wrap periods are 2 steps. Set to 0 mid-sweep → the wrap step issues its pulses, then `running`=0 and no further pulses occur.
- `enable` dropped on the edge where a step is due → no `rd_en_first`, state goes to IDLE, and `tone_idx` is held. Re-enabling restarts at `tone_idx`=0 with `sweep_start`.
- `dev_rst` asserted asynchronously mid-DWELL → all outputs read 0 before the next clock edge. After release with `enable`=1, the start sequence repeats from IDLE.

Source files
------------

// File: rtl/freq_ring_sequencer.sv
// Steps the frequency-selector rings at a programmable dwell period, tracking the
// current tone index and sweep boundaries, and defers steps while the rings are held.
module freq_ring_sequencer #(
    parameter int unsigned DWELL_W = 16,
    parameter int unsigned IDX_W   = 7
) (
    input  logic               dev_clk,
    input  logic               dev_rst,
    input  logic               enable,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [IDX_W-1:0]   num_tones,
    input  logic [3:0]         second_div,
    input  logic               ring_hold,
    input  logic               clr_stats,
    output logic               rd_en_first,
    output logic               rd_en_second,
    output logic [IDX_W-1:0]   tone_idx,
    output logic               sweep_start,
    output logic               running,
    output logic [7:0]         stall_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_DWELL, ST_HOLD} state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [3:0]         sub_q, sub_d;
    logic [IDX_W-1:0]   n_lat_q, n_lat_d;
    logic [IDX_W-1:0]   tone_idx_q, tone_idx_d;
    logic [7:0]         stall_cnt_q, stall_cnt_d;
    logic               rd_first_q, rd_first_d;
    logic               rd_second_q, rd_second_d;
    logic               sweep_q, sweep_d;
    logic               step;
    logic               stall_inc;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sub_d       = sub_q;
        n_lat_d     = n_lat_q;
        tone_idx_d  = tone_idx_q;
        rd_first_d  = 1'b0;
        rd_second_d = 1'b0;
        sweep_d     = 1'b0;
        step        = 1'b0;
        stall_inc   = 1'b0;

        // enable deassertion is checked first so it pre-empts a due step
        case (state_q)
            ST_IDLE: begin
                if (enable && (num_tones != '0)) begin
                    state_d    = ST_DWELL;
                    n_lat_d    = num_tones;
                    cnt_d      = dwell;
                    tone_idx_d = '0;
                    sub_d      = '0;
                    sweep_d    = 1'b1;
                end
            end
            ST_DWELL: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (ring_hold) begin
                    state_d   = ST_HOLD;
                    stall_inc = 1'b1;
                end else begin
                    step = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!ring_hold) begin
                    step = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (step) begin
            rd_first_d = 1'b1;
            cnt_d      = dwell;
            state_d    = ST_DWELL;
            if (tone_idx_q == (n_lat_q - IDX_W'(1))) begin
                tone_idx_d = '0;
                sweep_d    = 1'b1;
                n_lat_d    = num_tones;
                if (num_tones == '0) begin
                    state_d = ST_IDLE;
                end
            end else begin
                tone_idx_d = tone_idx_q + IDX_W'(1);
            end
            if (sub_q == second_div) begin
                rd_second_d = 1'b1;
                sub_d       = '0;
            end else begin
                sub_d = sub_q + 4'd1;
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (clr_stats) begin
            stall_cnt_d = '0;
        end else if (stall_inc && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge dev_clk or posedge dev_rst) begin
        if (dev_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sub_q       <= '0;
            n_lat_q     <= '0;
            tone_idx_q  <= '0;
            stall_cnt_q <= '0;
            rd_first_q  <= 1'b0;
            rd_second_q <= 1'b0;
            sweep_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sub_q       <= sub_d;
            n_lat_q     <= n_lat_d;
            tone_idx_q  <= tone_idx_d;
            stall_cnt_q <= stall_cnt_d;
            rd_first_q  <= rd_first_d;
            rd_second_q <= rd_second_d;
            sweep_q     <= sweep_d;
        end
    end

    assign rd_en_first  = rd_first_q;
    assign rd_en_second = rd_second_q;
    assign tone_idx     = tone_idx_q;
    assign sweep_start  = sweep_q;
    assign running      = (state_q != ST_IDLE);
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_freq_ring_sequencer.sv
// Directed self-checking bench for freq_ring_sequencer; observed vector is
// {running, sweep_start, rd_en_first, rd_en_second, tone_idx}.
module tb_freq_ring_sequencer;

    logic        dev_clk;
    logic        dev_rst;
    logic        enable;
    logic [15:0] dwell;
    logic [6:0]  num_tones;
    logic [3:0]  second_div;
    logic        ring_hold;
    logic        clr_stats;
    logic        rd_en_first;
    logic        rd_en_second;
    logic [6:0]  tone_idx;
    logic        sweep_start;
    logic        running;
    logic [7:0]  stall_cnt;

    int tests_run;
    int tests_failed;

    logic [10:0] obs;
    logic [10:0] exp_v;

    freq_ring_sequencer #(.DWELL_W(16), .IDX_W(7)) dut (
        .dev_clk      (dev_clk),
        .dev_rst      (dev_rst),
        .enable       (enable),
        .dwell        (dwell),
        .num_tones    (num_tones),
        .second_div   (second_div),
        .ring_hold    (ring_hold),
        .clr_stats    (clr_stats),
        .rd_en_first  (rd_en_first),
        .rd_en_second (rd_en_second),
        .tone_idx     (tone_idx),
        .sweep_start  (sweep_start),
        .running      (running),
        .stall_cnt    (stall_cnt)
    );

    assign obs = {running, sweep_start, rd_en_first, rd_en_second, tone_idx};

    initial begin
        dev_clk = 1'b0;
        forever #5 dev_clk = ~dev_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge dev_clk);
        #1;
    endtask

    task automatic apply_reset();
        dev_rst   = 1'b1;
        enable    = 1'b0;
        ring_hold = 1'b0;
        clr_stats = 1'b0;
        tick();
        tick();
        dev_rst = 1'b0;
    endtask

    task automatic test_reset();
        dev_rst    = 1'b1;
        enable     = 1'b1;
        dwell      = 16'd3;
        num_tones  = 7'd4;
        second_div = 4'd0;
        ring_hold  = 1'b0;
        clr_stats  = 1'b0;
        #2;
        tests_run++;
        if (obs !== 11'h000) begin
            $display("FAIL reset_outputs: got %h want %h", obs, 11'h000);
            tests_failed++;
        end
        tests_run++;
        if (stall_cnt !== 8'h00) begin
            $display("FAIL reset_stall: got %h want %h", stall_cnt, 8'h00);
            tests_failed++;
        end
        tick();
        tick();
        tests_run++;
        if (obs !== 11'h000) begin
            $display("FAIL reset_held: got %h want %h", obs, 11'h000);
            tests_failed++;
        end
        enable  = 1'b0;
        dev_rst = 1'b0;
        tick();
        tests_run++;
        if (obs !== 11'h000) begin
            $display("FAIL idle_no_enable: got %h want %h", obs, 11'h000);
            tests_failed++;
        end
    endtask

    task automatic test_basic_sweep();
        apply_reset();
        dwell      = 16'd3;
        num_tones  = 7'd4;
        second_div = 4'd0;
        enable     = 1'b1;
        tick();
        exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 7'd0};
        tests_run++;
        if (obs !== exp_v) begin
            $display("FAIL basic_start: got %h want %h", obs, exp_v);
            tests_failed++;
        end
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_v = {1'b1, (k == 16), (k % 4 == 0), (k % 4 == 0), 7'((k / 4) % 4)};
            tests_run++;
            if (obs !== exp_v) begin
                $display("FAIL basic_cycle_%0d: got %h want %h", k, obs, exp_v);
                tests_failed++;
            end
        end
    endtask

    task automatic test_second_div();
        apply_reset();
        dwell      = 16'd0;
        num_tones  = 7'd8;
        second_div = 4'd2;
        enable     = 1'b1;
        tick();
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_v = {1'b1, (k == 8), 1'b1, (k % 3 == 0), 7'(k % 8)};
            tests_run++;
            if (obs !== exp_v) begin
                $display("FAIL second_div_step_%0d: got %h want %h", k, obs, exp_v);
                tests_failed++;
            end
        end
    endtask

    task automatic test_hold();
        apply_reset();
        dwell      = 16'd3;
        num_tones  = 7'd4;
        second_div = 4'd0;
        enable     = 1'b1;
        tick();
        tick(); tick(); tick();
        ring_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 7'd0};
            tests_run++;
            if (obs !== exp_v) begin
                $display("FAIL hold_wait_%0d: got %h want %h", i, obs, exp_v);
                tests_failed++;
            end
        end
        tests_run++;
        if (stall_cnt !== 8'd1) begin
            $display("FAIL hold_stall_1: got %0d want %0d", stall_cnt, 1);
            tests_failed++;
        end
        ring_hold = 1'b0;
        tick();
        exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 7'd1};
        tests_run++;
        if (obs !== exp_v) begin
            $display("FAIL hold_delayed_step: got %h want %h", obs, exp_v);
            tests_failed++;
        end
        tick(); tick(); tick();
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 7'd1};
        tests_run++;
        if (obs !== exp_v) begin
            $display("FAIL hold_respace_quiet: got %h want %h", obs, exp_v);
            tests_failed++;
        end
        tick();
        exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 7'd2};
        tests_run++;
        if (obs !== exp_v) begin
            $display("FAIL hold_respace_step: got %h want %h", obs, exp_v);
            tests_failed++;
        end
        tick(); tick(); tick();
        ring_hold = 1'b1;
        tick(); tick();
        ring_hold = 1'b0;
        tests_run++;
        if (stall_cnt !== 8'd2) begin
            $display("FAIL hold_stall_2: got %0d want %0d", stall_cnt, 2);
            tests_failed++;
        end
        tick();
        exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 7'd3};
        tests_run++;
        if (obs !== exp_v) begin
            $display("FAIL hold2_step: got %h want %h", obs, exp_v);
            tests_failed++;
        end
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        tests_run++;
        if (stall_cnt !== 8'd0) begin
            $display("FAIL clr_stats: got %0d want %0d", stall_cnt, 0);
            tests_failed++;
        end
        tick(); tick();
        ring_hold = 1'b1;
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        tests_run++;
        if (stall_cnt !== 8'd0) begin
            $display("FAIL clr_beats_inc: got %0d want %0d", stall_cnt, 0);
            tests_failed++;
        end
        tick();
        ring_hold = 1'b0;
        tick();
        exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 7'd0};
        tests_run++;
        if (obs !== exp_v) begin
            $display("FAIL hold3_wrap_step: got %h want %h", obs, exp_v);
            tests_failed++;
        end
    endtask

    task automatic test_num_tones_change();
        logic [6:0] idx_tab [8];
        logic       sw_tab  [8];
        idx_tab = '{7'd1, 7'd2, 7'd3, 7'd0, 7'd1, 7'd0, 7'd1, 7'd0};
        sw_tab  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        dwell      = 16'd0;
        num_tones  = 7'd4;
        second_div = 4'd0;
        enable     = 1'b1;
        tick();
        num_tones = 7'd2;
        for (int k = 0; k < 7; k++) begin
            tick();
            exp_v = {1'b1, sw_tab[k], 1'b1, 1'b1, idx_tab[k]};
            tests_run++;
            if (obs !== exp_v) begin
                $display("FAIL ntones_step_%0d: got %h want %h", k + 1, obs, exp_v);
                tests_failed++;
            end
        end
        num_tones = 7'd0;
        tick();
        exp_v = {1'b0, sw_tab[7], 1'b1, 1'b1, idx_tab[7]};
        tests_run++;
        if (obs[9:0] !== exp_v[9:0]) begin
            $display("FAIL ntones_zero_wrap: got %h want %h", obs[9:0], exp_v[9:0]);
            tests_failed++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
            tests_run++;
            if (obs !== exp_v) begin
                $display("FAIL ntones_stopped_%0d: got %h want %h", i, obs, exp_v);
                tests_failed++;
            end
        end
    endtask

    task automatic test_enable_drop();
        apply_reset();
        dwell      = 16'd3;
        num_tones  = 7'd4;
        second_div = 4'd0;
        enable     = 1'b1;
        tick();
        tick(); tick(); tick(); tick();
        exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 7'd1};
        tests_run++;
        if (obs !== exp_v) begin
            $display("FAIL drop_first_step: got %h want %h", obs, exp_v);
            tests_failed++;
        end
        tick(); tick(); tick();
        enable = 1'b0;
        tick();
        exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 7'd1};
        tests_run++;
        if (obs !== exp_v) begin
            $display("FAIL drop_beats_step: got %h want %h", obs, exp_v);
            tests_failed++;
        end
        tick(); tick(); tick();
        tests_run++;
        if (obs !== exp_v) begin
            $display("FAIL drop_idx_held: got %h want %h", obs, exp_v);
            tests_failed++;
        end
        enable = 1'b1;
        tick();
        exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 7'd0};
        tests_run++;
        if (obs !== exp_v) begin
            $display("FAIL drop_restart: got %h want %h", obs, exp_v);
            tests_failed++;
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        dwell      = 16'd3;
        num_tones  = 7'd4;
        second_div = 4'd0;
        enable     = 1'b1;
        tick();
        tick(); tick(); tick(); tick();
        exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 7'd1};
        tests_run++;
        if (obs !== exp_v) begin
            $display("FAIL areset_pre: got %h want %h", obs, exp_v);
            tests_failed++;
        end
        dev_rst = 1'b1;
        #1;
        tests_run++;
        if (obs !== 11'h000) begin
            $display("FAIL areset_immediate: got %h want %h", obs, 11'h000);
            tests_failed++;
        end
        tick();
        dev_rst = 1'b0;
        tick();
        exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 7'd0};
        tests_run++;
        if (obs !== exp_v) begin
            $display("FAIL areset_restart: got %h want %h", obs, exp_v);
            tests_failed++;
        end
        tick(); tick(); tick(); tick();
        exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 7'd1};
        tests_run++;
        if (obs !== exp_v) begin
            $display("FAIL areset_first_step: got %h want %h", obs, exp_v);
            tests_failed++;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic_sweep();
        test_second_div();
        test_hold();
        test_num_tones_change();
        test_enable_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
